// File: rtl/main_mem_timed.sv
// Word-addressed main memory behind the write-back cache; every access completes LATENCY+1 cycles after acceptance.
// Optional MAIN_MEM_ALIGN_CHECK_EN: flag misaligned accesses on err, suppress the write, and return 0 on a read.
module main_mem_timed #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              request,
    input  logic              read_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              done,
`ifdef MAIN_MEM_ALIGN_CHECK_EN
    output logic              err,
`endif
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_we;
    logic                access_bad;
    logic [DATA_W-1:0]   mem [DEPTH];

`ifdef MAIN_MEM_ALIGN_CHECK_EN
    logic                mis_q, mis_d;
    logic                err_q, err_d;
    assign access_bad = mis_q;
    assign err        = err_q;
`else
    logic                addr_lo_unused;
    assign access_bad     = 1'b0;
    assign addr_lo_unused = ^address[1:0];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef MAIN_MEM_ALIGN_CHECK_EN
        mis_d   = mis_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (request) begin
                    rw_d    = read_write;
                    idx_d   = address[ADDR_W-1:2];
                    wdata_d = write_data;
`ifdef MAIN_MEM_ALIGN_CHECK_EN
                    mis_d   = |address[1:0];
`endif
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // The access itself happens on the WAIT->DONE edge so results are visible with done.
                    if (rw_q) begin
                        mem_we = ~access_bad;
                    end else begin
                        rdata_d = access_bad ? '0 : mem[idx_q];
                    end
`ifdef MAIN_MEM_ALIGN_CHECK_EN
                    err_d   = mis_q;
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MAIN_MEM_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MAIN_MEM_ALIGN_CHECK_EN
            mis_q   <= mis_d;
            err_q   <= err_d;
`endif
        end
    end

    // Array is never cleared; a write coinciding with reset is abandoned.
    always_ff @(posedge clock) begin
        if (mem_we && reset_n) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign read_data = rdata_q;

endmodule

// File: tb/tb_main_mem_timed.sv
// Directed table-driven bench for main_mem_timed plus hand-written back-to-back, reset and latching sequences.
module tb_main_mem_timed;

    localparam int LAT = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        request;
    logic        read_write;
    logic [9:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        done;
    logic        busy;
    logic        err;

    main_mem_timed #(.ADDR_W(10), .DATA_W(32), .LATENCY(LAT), .DEPTH(256)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .request    (request),
        .read_write (read_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .done       (done),
`ifdef MAIN_MEM_ALIGN_CHECK_EN
        .err        (err),
`endif
        .busy       (busy)
    );

`ifndef MAIN_MEM_ALIGN_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clock = ~clock;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    typedef struct {
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it idle the same way.
    task automatic access(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                          input bit perturb, output int lat, output logic [31:0] rd,
                          output logic er, output bit busy_bad);
        read_write = rw;
        address    = a;
        write_data = wd;
        request    = 1'b1;
        lat        = 99;
        rd         = '0;
        er         = 1'b0;
        busy_bad   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (busy !== (k != 0)) busy_bad = 1'b1;
            if (done === 1'b1) begin
                lat = k;
                rd  = read_data;
                er  = err;
                break;
            end
            if (perturb && k == 2) begin
                read_write = ~rw;
                address    = a + 10'd4;
                write_data = ~wd;
            end
            @(posedge clock); #1;
        end
        request = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        bit          bb;
        int          dcnt;
        int          t0, t1, idle_cnt;
        logic [31:0] r0, r1;

        vt[0] = '{1'b1, 10'h010, 32'hDEADBEEF, 32'h0,        1'b0, "wr_010"};
        vt[1] = '{1'b0, 10'h010, 32'h0,        32'hDEADBEEF, 1'b0, "rd_010"};
        vt[2] = '{1'b1, 10'h3FC, 32'h12345678, 32'hDEADBEEF, 1'b0, "wr_3fc"};
`ifdef MAIN_MEM_ALIGN_CHECK_EN
        vt[3] = '{1'b0, 10'h3FD, 32'h0,        32'h0,        1'b1, "rd_3fd"};
`else
        vt[3] = '{1'b0, 10'h3FD, 32'h0,        32'h12345678, 1'b0, "rd_3fd"};
`endif
        vt[4] = '{1'b1, 10'h004, 32'h00000001, vt[3].exp_rd, 1'b0, "wr_004"};
        vt[5] = '{1'b1, 10'h008, 32'h00000002, vt[3].exp_rd, 1'b0, "wr_008"};
        vt[6] = '{1'b1, 10'h020, 32'h11112222, vt[3].exp_rd, 1'b0, "wr_020"};
        vt[7] = '{1'b0, 10'h020, 32'h0,        32'h11112222, 1'b0, "rd_020"};

        request    = 1'b0;
        read_write = 1'b0;
        address    = '0;
        write_data = '0;
        reset_n    = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        @(negedge clock);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_rdata", read_data, 32'd0);
`ifdef MAIN_MEM_ALIGN_CHECK_EN
        check("reset_err", {31'b0, err}, 32'd0);
`endif
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done !== 1'b0) dcnt++;
        end
        check("idle_no_done", dcnt, 0);
        @(posedge clock); #1;

        for (int i = 0; i < 8; i++) begin
            access(vt[i].rw, vt[i].addr, vt[i].wd, 1'b0, lat, rd, er, bb);
            check({vt[i].name, "_lat"}, lat, LAT + 1);
            check({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
            check({vt[i].name, "_busy"}, {31'b0, bb}, 32'd0);
`ifdef MAIN_MEM_ALIGN_CHECK_EN
            check({vt[i].name, "_err"}, {31'b0, er}, {31'b0, vt[i].exp_err});
`endif
        end

        // Back-to-back reads with request held high through the first done.
        read_write = 1'b0;
        address    = 10'h004;
        request    = 1'b1;
        t0 = -1; t1 = -1; idle_cnt = 0; r0 = '0; r1 = '0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            if (t0 >= 0 && t1 < 0 && busy !== 1'b1) idle_cnt++;
            if (done === 1'b1) begin
                if (t0 < 0) begin
                    t0 = t;
                    r0 = read_data;
                    address = 10'h008;
                end else begin
                    t1 = t;
                    r1 = read_data;
                    request = 1'b0;
                    break;
                end
            end
        end
        @(posedge clock); #1;
        check("b2b_first_lat", t0, LAT + 1);
        check("b2b_spacing", t1 - t0, LAT + 2);
        check("b2b_rdata0", r0, 32'h1);
        check("b2b_rdata1", r1, 32'h2);
        check("b2b_idle_cycles", idle_cnt, 1);

        // Reset during the second WAIT cycle of a write.
        read_write = 1'b1;
        address    = 10'h020;
        write_data = 32'hAAAA5555;
        request    = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b0;
        request = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_rdata", read_data, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done !== 1'b0) dcnt++;
        end
        check("midrst_no_done", dcnt, 0);
        @(posedge clock); #1;
        access(1'b0, 10'h020, 32'h0, 1'b0, lat, rd, er, bb);
        check("midrst_readback", rd, 32'h11112222);

        // Inputs changed during WAIT must not affect the latched write.
        access(1'b1, 10'h044, 32'h55555555, 1'b0, lat, rd, er, bb);
        access(1'b1, 10'h040, 32'hCAFEF00D, 1'b1, lat, rd, er, bb);
        check("latch_lat", lat, LAT + 1);
        check("latch_busy", {31'b0, bb}, 32'd0);
        access(1'b0, 10'h040, 32'h0, 1'b0, lat, rd, er, bb);
        check("latch_orig_addr", rd, 32'hCAFEF00D);
        access(1'b0, 10'h044, 32'h0, 1'b0, lat, rd, er, bb);
        check("latch_other_addr", rd, 32'h55555555);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/main_mem_timed.md
Name: main_mem_timed

Overview:
- Clocked main-memory model sitting directly downstream of the direct-mapped write-back cache.
- Services the cache's single-word read and write-back requests over the read_write / address / write_data / read_data / done interface, after a fixed, parameterised access latency.
- Replaces the zero-latency behavioural memory, so cache miss and write-back stalls become cycle-accurate.

Parameters:
- ADDR_W, 10, byte address width (1 KiB space).
- DATA_W, 32, word width.
- LATENCY, 4, cycles from request acceptance to done; legal range 1..15.
- DEPTH, 256, number of words (2^(ADDR_W-2)).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- request  input  1  cache asserts to start an access; must be held until done.
- read_write  input  1  1 = write, 0 = read; sampled when request is accepted.
- address  input  ADDR_W  byte address; word index = address[ADDR_W-1:2].
- write_data  input  DATA_W  write word; sampled when request is accepted.
- read_data  output  DATA_W  read result; valid in the cycle done=1, held until the next accept.
- done  output  1  one-cycle pulse marking access completion.
- busy  output  1  high from accept until the cycle done is asserted, inclusive.

Behaviour:
- Reset: the synchronous, active-low reset is sampled only on the rising edge of clock.
  - Clears state to IDLE, done=0, busy=0, read_data=0 and the latency counter.
  - Memory array contents are not cleared.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if request=1, latch read_write, word index and write_data; load counter with LATENCY-1; go to WAIT; busy=1 from the next cycle.
  - WAIT: decrement the counter each cycle; at counter==0 perform the access and go to DONE.
    - Write: mem[idx] <= wdata.
    - Read: read_data <= mem[idx].
  - DONE: done=1, busy=1 for exactly one cycle; then go to IDLE.
- Latency: with request rising in cycle N, done is high in cycle N+LATENCY+1, and no earlier for any legal LATENCY.
- Back-to-back requests:
  - request still high in the cycle after DONE is treated as a new request and accepted from IDLE.
  - Minimum spacing between done pulses is LATENCY+2 cycles.
- Input changes: the latched request is used throughout. Changes to read_write, address or write_data after acceptance have no effect.
- request dropping mid-access: the access still completes and done still pulses; there is no abort.
- Address handling: address[1:0] is ignored for indexing (word-aligned). The index wraps naturally within DEPTH.
- Write then read of the same word: the read returns the newly written value. There is no read-before-write hazard because accesses are serialised.
- Reset asserted in WAIT or DONE:
  - Access is abandoned and no done pulse is produced.
  - A pending write is not performed unless the write cycle already passed.
- read_data is updated only on read completion. Writes leave it unchanged.

Optional Feature:
- Macro: MAIN_MEM_ALIGN_CHECK_EN.
- When defined:
  - Extra output port err (1 bit, reset 0).
  - A request with address[1:0]!=0 is still accepted and timed normally.
  - At completion, a write is suppressed, a read returns 0, and err=1 in the same cycle as done (one-cycle pulse).
- When undefined: no err port; low address bits are silently ignored as above.

Test Plan:
- Reset, LATENCY=4: hold reset_n=0 for 2 cycles, then release.
  - Required: done=0, busy=0, read_data=0.
  - Required: no done pulse while request=0 for 10 cycles.
- Write then read, LATENCY=4:
  - Write 0xDEADBEEF to address 0x010, request rising in cycle N: done exactly in cycle N+5.
  - Then read address 0x010: read_data=0xDEADBEEF with done.
- Aliasing: write 0x12345678 to 0x3FC, then read 0x3FD.
  - Required: returns 0x12345678 (low bits ignored).
  - With MAIN_MEM_ALIGN_CHECK_EN: read returns 0 and err=1.
- Back-to-back: hold request high across two reads (addresses 0x004, 0x008 preloaded with 0x1, 0x2).
  - Required: done pulses 6 cycles apart.
  - Required: read_data sequence is 0x1 then 0x2; busy never drops between them except the single IDLE cycle.
- Mid-access reset: start a write of 0xAAAA5555 to 0x020, then assert reset_n=0 in the second WAIT cycle.
  - Required: no done pulse.
  - Required: a subsequent read of 0x020 returns the prior contents.
- Latched inputs: during WAIT, toggle read_write and change address/write_data.
  - Required: the originally latched write lands at the original address; the other location is unchanged.
